// File: rtl/synapse_host_bridge.sv
// synapse_host_bridge: host-side master for the Synapse-1 pin interface.
// Sequences chip reset/enable, strobes addr/data bytes, and returns the acked uo_out byte.
`default_nettype none

module synapse_host_bridge #(
  parameter int STROBE_CYCLES   = 2,
  parameter int ACK_TIMEOUT     = 255,
  parameter int CHIP_RST_CYCLES = 8,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       stuck_ack,
  output logic       pin_ena,
  output logic       pin_rst_n,
  output logic [7:0] pin_ui,
  output logic [7:0] pin_uio,
  input  logic [7:0] pin_uo,
  input  logic [7:0] pin_uio_oe
);

  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  typedef enum logic [2:0] {
    S_CHIP_RST  = 3'd0,
    S_IDLE      = 3'd1,
    S_SEND_ADDR = 3'd2,
    S_SEND_DATA = 3'd3,
    S_WAIT_ACK  = 3'd4,
    S_RESP      = 3'd5,
    S_DRAIN     = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [1:0]             op_q, op_d;
  logic [7:0]             addr_q, addr_d;
  logic [7:0]             data_q, data_d;
  logic [7:0]             rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   stuck_q, stuck_d;
  logic                   chip_rst_n_q, chip_rst_n_d;
  logic                   ena_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic                   unused_uio_oe;

  assign ack_s         = sync_q[SYNC_STAGES-1];
  assign unused_uio_oe = &{1'b0, pin_uio_oe[6:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_CHIP_RST;
      cnt_q        <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      stuck_q      <= 1'b0;
      chip_rst_n_q <= 1'b0;
      ena_q        <= 1'b0;
      sync_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      stuck_q      <= stuck_d;
      chip_rst_n_q <= chip_rst_n_d;
      ena_q        <= 1'b1;
      sync_q       <= (sync_q << 1) | SYNC_STAGES'(pin_uio_oe[7]);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 16'd1;
    op_d         = op_q;
    addr_d       = addr_q;
    data_d       = data_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    stuck_d      = stuck_q;
    chip_rst_n_d = chip_rst_n_q;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    pin_ui       = 8'h00;
    pin_uio      = 8'h00;

    unique case (state_q)
      S_CHIP_RST: begin
        if (cnt_q == 16'(CHIP_RST_CYCLES)) begin
          chip_rst_n_d = 1'b1;
          cnt_d        = '0;
          state_d      = S_IDLE;
        end
      end
      S_IDLE: begin
        cmd_ready = 1'b1;
        cnt_d     = '0;
        if (cmd_valid) begin
          op_d   = cmd_op;
          addr_d = cmd_addr;
          // READ carries no payload; the data phase still runs with a zero byte.
          data_d = (cmd_op == OP_READ) ? 8'h00 : cmd_data;
          if (cmd_op == OP_NOP) begin
            rsp_data_d = 8'h00;
            rsp_err_d  = 1'b0;
            state_d    = S_RESP;
          end else begin
            state_d = S_SEND_ADDR;
          end
        end
      end
      S_SEND_ADDR: begin
        pin_ui  = addr_q;
        pin_uio = {4'b0000, 1'b0, 1'b1, op_q};
        if (cnt_q == 16'(STROBE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_SEND_DATA;
        end
      end
      S_SEND_DATA: begin
        pin_ui  = data_q;
        pin_uio = {4'b0000, 1'b1, 1'b1, op_q};
        if (cnt_q == 16'(STROBE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (ack_s) begin
          rsp_data_d = pin_uo;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (cnt_q == 16'(ACK_TIMEOUT - 1)) begin
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        cnt_d     = '0;
        if (rsp_ready) begin
          // Only a real chip transfer leaves ack high that must be seen falling.
          state_d = (op_q == OP_NOP || rsp_err_q) ? S_IDLE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!ack_s) begin
          state_d = S_IDLE;
        end else if (cnt_q == 16'(ACK_TIMEOUT - 1)) begin
          stuck_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_CHIP_RST;
    endcase
  end

  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign stuck_ack = stuck_q;
  assign pin_ena   = ena_q;
  assign pin_rst_n = chip_rst_n_q;

endmodule

`default_nettype wire
